move_cmd_gen: RTL and testbench

Front end for the cursor-movement logic on the 8x8 board. Takes four raw push-button inputs and produces the isUp/isDown/isLeft/isRight command pulses that the movement block consumes. The block synchronises and debounces each button, then emits exactly one single-cycle direction pulse per press, with auto-repeat while a button is held. Pulses are registered on the rising clk edge, so they are stable when the movement block samples on the falling edge.

---
 rtl/move_cmd_pkg.sv | 46 ++++
 rtl/btn_debounce.sv | 42 ++++
 rtl/move_cmd_gen.sv | 132 +++++++++++++
 tb/tb_move_cmd_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/move_cmd_pkg.sv
// Shared types, default timing and direction helpers for the button-to-move
// command front end.
package move_cmd_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        HOLD_DELAY,
        REPEAT,
        LOCKOUT
    } cmd_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_RATE     = 5000000;

    // Button vectors are ordered {right, left, down, up}.
    function automatic dir_t dir_of(input logic [3:0] m);
        case (m)
            4'b0001: return DIR_UP;
            4'b0010: return DIR_DOWN;
            4'b0100: return DIR_LEFT;
            4'b1000: return DIR_RIGHT;
            default: return DIR_NONE;
        endcase
    endfunction

    function automatic logic [3:0] dir_mask(input dir_t d);
        case (d)
            DIR_UP:    return 4'b0001;
            DIR_DOWN:  return 4'b0010;
            DIR_LEFT:  return 4'b0100;
            DIR_RIGHT: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser and debounce counter for one active-low push button;
// level is 1 while debounced-pressed, rise pulses for the cycle it turns on.
module btn_debounce
    import move_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], ~btn_n};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/move_cmd_gen.sv
// Turns four raw push buttons into single-cycle, mutually exclusive direction
// pulses with auto-repeat while one button is held.
module move_cmd_gen
    import move_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_n,
    input  logic btn_down_n,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic enable,
    output logic isUp,
    output logic isDown,
    output logic isLeft,
    output logic isRight,
    output logic held
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX) + 1;

    logic [3:0]    lvl;
    logic [3:0]    rise;
    cmd_state_t    state, state_d;
    dir_t          dir_q, dir_d;
    logic [RW-1:0] rcnt, rcnt_d;
    logic [3:0]    pulse_q, pulse_d;
    logic          en_q;
    logic [3:0]    act;
    logic          act_released;
    logic          other_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn_n(btn_up_n), .level(lvl[0]), .rise(rise[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn_n(btn_down_n), .level(lvl[1]), .rise(rise[1])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk), .rst(rst), .btn_n(btn_left_n), .level(lvl[2]), .rise(rise[2])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk), .rst(rst), .btn_n(btn_right_n), .level(lvl[3]), .rise(rise[3])
    );

    assign act          = dir_mask(dir_q);
    assign act_released = (lvl & act) == 4'b0000;
    assign other_rise   = |(rise & ~act);

    // Pulses are registered, so the pulse for FIRST is produced on the edge that
    // enters FIRST; the repeat counter is loaded there too (one less than the
    // delay) so the first repeat lands exactly REPEAT_DELAY cycles later.
    always_comb begin
        state_d = state;
        dir_d   = dir_q;
        rcnt_d  = (rcnt != '0) ? rcnt - RW'(1) : rcnt;
        pulse_d = '0;
        if (!enable) begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
        end else if (!en_q && (|lvl)) begin
            state_d = LOCKOUT;
            dir_d   = DIR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if ($countones(rise) >= 2) begin
                        state_d = LOCKOUT;
                    end else if ($countones(rise) == 1) begin
                        state_d = FIRST;
                        dir_d   = dir_of(rise);
                        pulse_d = rise;
                        rcnt_d  = RW'(REPEAT_DELAY - 1);
                    end
                end
                FIRST, HOLD_DELAY, REPEAT: begin
                    if (act_released) begin
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
                    end else if (other_rise) begin
                        state_d = LOCKOUT;
                        dir_d   = DIR_NONE;
                    end else if (state == FIRST) begin
                        state_d = HOLD_DELAY;
                    end else if (rcnt == '0) begin
                        state_d = REPEAT;
                        pulse_d = act;
                        rcnt_d  = RW'(REPEAT_RATE - 1);
                    end
                end
                LOCKOUT: begin
                    if (lvl == 4'b0000) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dir_d   = DIR_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dir_q   <= DIR_NONE;
            rcnt    <= '0;
            pulse_q <= '0;
            en_q    <= 1'b0;
            held    <= 1'b0;
        end else begin
            state   <= state_d;
            dir_q   <= dir_d;
            rcnt    <= rcnt_d;
            pulse_q <= pulse_d;
            en_q    <= enable;
            held    <= (state_d == HOLD_DELAY) || (state_d == REPEAT);
        end
    end

    assign isUp    = pulse_q[0];
    assign isDown  = pulse_q[1];
    assign isLeft  = pulse_q[2];
    assign isRight = pulse_q[3];

endmodule

// File: tb/tb_move_cmd_gen.sv
// Directed bench for move_cmd_gen: stimulus queues expected pulses, a monitor
// pops and compares every pulse the DUT presents.
module tb_move_cmd_gen;
    import move_cmd_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RR = 8;
    localparam logic [3:0] M_UP = 4'b0001, M_DOWN = 4'b0010, M_LEFT = 4'b0100, M_RIGHT = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up_n = 1'b1, btn_down_n = 1'b1, btn_left_n = 1'b1, btn_right_n = 1'b1;
    logic enable = 1'b1;
    logic isUp, isDown, isLeft, isRight, held;

    move_cmd_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .btn_left_n(btn_left_n), .btn_right_n(btn_right_n),
        .enable(enable),
        .isUp(isUp), .isDown(isDown), .isLeft(isLeft), .isRight(isRight),
        .held(held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] dir;
    } exp_t;
    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [3:0] d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pulses are compared against the queue head on the falling edge.
    always @(negedge clk) begin
        logic [3:0] p;
        exp_t e;
        p = {isRight, isLeft, isDown, isUp};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_pulse: required dir %b at cycle %0d not observed (now %0d)",
                     q[0].dir, q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (p != 4'b0000) begin
            check("onehot", $countones(p), 1);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got dir %b at cycle %0d, required none", p, cyc);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_dir", int'(p), int'(e.dir));
            end
        end
    end

    initial begin
        int base;

        // Reset state
        #3;
        check("reset_outputs", int'({isUp, isDown, isLeft, isRight, held}), 0);
        check("reset_state", int'(dut.state), int'(IDLE));
        idle(3);
        rst = 1'b1;
        idle(3);

        // Clean press, held 10 cycles
        base = cyc;
        expect_pulse(base + 7, M_UP);
        btn_up_n = 1'b0;
        idle(9);
        check("held_in_hold", int'(held), 1);
        idle(1);
        btn_up_n = 1'b1;
        idle(6);
        check("held_before_release", int'(held), 1);
        idle(1);
        check("held_after_release", int'(held), 0);
        idle(10);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            btn_left_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                idle(1);
                check("bounce_level", int'(dut.lvl[2]), 0);
            end
        end
        btn_left_n = 1'b1;
        idle(10);
        check("bounce_held", int'(held), 0);
        check("bounce_state", int'(dut.state), int'(IDLE));

        // Auto-repeat, 60 cycle hold
        base = cyc;
        expect_pulse(base + 7,  M_RIGHT);
        expect_pulse(base + 27, M_RIGHT);
        expect_pulse(base + 35, M_RIGHT);
        expect_pulse(base + 43, M_RIGHT);
        expect_pulse(base + 51, M_RIGHT);
        expect_pulse(base + 59, M_RIGHT);
        btn_right_n = 1'b0;
        idle(30);
        check("repeat_state", int'(dut.state), int'(REPEAT));
        idle(30);
        btn_right_n = 1'b1;
        idle(20);
        check("repeat_done_held", int'(held), 0);

        // Chord: up and down on the same edge
        btn_up_n   = 1'b0;
        btn_down_n = 1'b0;
        idle(8);
        check("chord_lockout", int'(dut.state), int'(LOCKOUT));
        check("chord_held", int'(held), 0);
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        idle(18);
        check("chord_idle", int'(dut.state), int'(IDLE));
        base = cyc;
        expect_pulse(base + 7, M_DOWN);
        btn_down_n = 1'b0;
        idle(5);
        btn_down_n = 1'b1;
        idle(15);

        // Enable gating
        enable   = 1'b0;
        btn_up_n = 1'b0;
        idle(10);
        check("disabled_state", int'(dut.state), int'(IDLE));
        enable = 1'b1;
        idle(1);
        check("enable_rise_lockout", int'(dut.state), int'(LOCKOUT));
        idle(9);
        btn_up_n = 1'b1;
        idle(12);
        check("enable_release_idle", int'(dut.state), int'(IDLE));
        base = cyc;
        expect_pulse(base + 7, M_UP);
        btn_up_n = 1'b0;
        idle(5);
        btn_up_n = 1'b1;
        idle(15);

        // Asynchronous reset during REPEAT with the button held
        base = cyc;
        expect_pulse(base + 7,  M_UP);
        expect_pulse(base + 27, M_UP);
        btn_up_n = 1'b0;
        idle(30);
        check("pre_reset_state", int'(dut.state), int'(REPEAT));
        rst = 1'b0;
        #1;
        check("async_reset_outputs", int'({isUp, isDown, isLeft, isRight, held}), 0);
        check("async_reset_state", int'(dut.state), int'(IDLE));
        idle(1);
        rst  = 1'b1;
        base = cyc;
        expect_pulse(base + 7, M_UP);
        idle(12);
        btn_up_n = 1'b1;
        idle(15);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
